// File: rtl/sub_bytes_seq_pkg.sv
// Shared types for the time-shared SubBytes / SubWord engine.
package sub_bytes_seq_pkg;

  // AES state, row-major: [row][col][bit]
  typedef logic [3:0][3:0][7:0] state_t;
  typedef logic [3:0][7:0]      word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  typedef enum logic {
    CIPHER = 1'b0,
    KS     = 1'b1
  } owner_t;

  localparam int unsigned NUM_SBOX = 4;

endpackage

// File: rtl/sub_bytes_seq_sbox.sv
// AES forward S-box implemented as a constant 256-entry ROM.
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = TBL[i_byte];

endmodule

// File: rtl/sub_bytes_seq.sv
// Time-shares four S-boxes between a row-per-beat cipher SubBytes job and
// single-beat key-schedule SubWord requests.
module sub_bytes_seq
  import sub_bytes_seq_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state,
  input  logic   ks_valid,
  output logic   ks_ready,
  input  word_t  ks_word,
  output logic   ks_res_valid,
  output word_t  ks_res,
  output logic   busy
);

  fsm_t       r_state;
  fsm_t       w_state_nxt;
  logic [1:0] r_beat;
  owner_t     r_prev;
  state_t     r_buf;
  word_t      r_ks_res;
  logic       r_ks_res_valid;

  logic       w_ks_grant;
  logic       w_c_beat;
  logic       w_in_ready;
  logic       w_accept;
  word_t      w_sb_in;
  word_t      w_sb_out;

  always_comb begin
    w_state_nxt = r_state;
    w_ks_grant  = 1'b0;
    w_c_beat    = 1'b0;
    w_in_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_ks_grant = ks_valid;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        // With FAIR the key schedule may not take two RUN slots in a row.
        w_ks_grant = ks_valid && (!FAIR || (r_prev == CIPHER));
        w_c_beat   = !w_ks_grant;
        if (w_c_beat && (r_beat == 2'd3)) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_in_ready = out_ready;
        w_ks_grant = ks_valid;
        if (out_ready) w_state_nxt = in_valid ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_in_ready && in_valid;
  assign w_sb_in  = w_ks_grant ? ks_word : r_buf[r_beat];

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    sbox u_sbox (
      .i_byte (w_sb_in[g]),
      .o_byte (w_sb_out[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_beat         <= '0;
      r_prev         <= CIPHER;
      r_buf          <= '0;
      r_ks_res       <= '0;
      r_ks_res_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ks_res_valid <= w_ks_grant;
      if (w_ks_grant) r_ks_res <= w_sb_out;
      if (w_accept) begin
        r_buf  <= in_state;
        r_beat <= '0;
      end else if (w_c_beat) begin
        r_buf[r_beat] <= w_sb_out;
        r_beat        <= r_beat + 2'd1;
      end
      // Only RUN slots are contended, so only they record the owner.
      if (r_state == RUN) r_prev <= w_ks_grant ? KS : CIPHER;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = (r_state == HOLD);
  assign out_state    = r_buf;
  assign ks_ready     = w_ks_grant;
  assign ks_res_valid = r_ks_res_valid;
  assign ks_res       = r_ks_res;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: one FAIR=1 and one FAIR=0 instance on shared inputs,
// checked against a GF(2^8) inverse/affine S-box model.
module tb_sub_bytes_seq;
  import sub_bytes_seq_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   in_valid, out_ready, ks_valid;
  state_t in_state;
  word_t  ks_word;

  logic   f1_in_ready, f1_out_valid, f1_ks_ready, f1_ks_res_valid, f1_busy;
  state_t f1_out_state;
  word_t  f1_ks_res;
  logic   f0_in_ready, f0_out_valid, f0_ks_ready, f0_ks_res_valid, f0_busy;
  state_t f0_out_state;
  word_t  f0_ks_res;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sub_bytes_seq #(.FAIR(1'b1)) u_f1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f1_in_ready), .in_state(in_state),
    .out_valid(f1_out_valid), .out_ready(out_ready), .out_state(f1_out_state),
    .ks_valid(ks_valid), .ks_ready(f1_ks_ready), .ks_word(ks_word),
    .ks_res_valid(f1_ks_res_valid), .ks_res(f1_ks_res), .busy(f1_busy)
  );

  sub_bytes_seq #(.FAIR(1'b0)) u_f0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f0_in_ready), .in_state(in_state),
    .out_valid(f0_out_valid), .out_ready(out_ready), .out_state(f0_out_state),
    .ks_valid(ks_valid), .ks_ready(f0_ks_ready), .ks_word(ks_word),
    .ks_res_valid(f0_ks_res_valid), .ks_res(f0_ks_res), .busy(f0_busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv, r;
    inv = '0;
    for (int i = 1; i < 256; i++)
      if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return r;
  endfunction

  function automatic word_t sub_word(input word_t w);
    word_t o;
    for (int i = 0; i < 4; i++) o[i] = sb(w[i]);
    return o;
  endfunction

  function automatic state_t sub_state(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[r][c] = sb(s[r][c]);
    return o;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = 8'($urandom);
    return s;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input state_t obs, input state_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input word_t obs, input word_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t st, st2, exp_s, all63;
    word_t  w;
    int     hold;
    logic   g;

    all63 = {16{8'h63}};
    in_valid = 1'b0; out_ready = 1'b1; ks_valid = 1'b0;
    in_state = '0; ks_word = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready_f1", f1_in_ready, 1'b1);
    chk1("rst_out_valid_f1", f1_out_valid, 1'b0);
    chk1("rst_busy_f1", f1_busy, 1'b0);
    chk1("rst_ks_res_valid_f1", f1_ks_res_valid, 1'b0);
    chk1("rst_ks_ready_f1", f1_ks_ready, 1'b0);
    chk_s("rst_out_state_f1", f1_out_state, '0);
    chk_w("rst_ks_res_f1", f1_ks_res, '0);
    chk1("rst_busy_f0", f0_busy, 1'b0);
    chk_s("rst_out_state_f0", f0_out_state, '0);
    rst = 1'b1;
    tick();

    // All-zero state, no key-schedule traffic: out_valid at cycle 5
    in_state = '0; in_valid = 1'b1; #1;
    chk1("c0_in_ready_f1", f1_in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk1("zero_out_valid_early_f1", f1_out_valid, 1'b0);
      chk1("zero_out_valid_early_f0", f0_out_valid, 1'b0);
      chk1("zero_busy_f1", f1_busy, 1'b1);
      chk1("zero_in_ready_run_f1", f1_in_ready, 1'b0);
      tick();
    end
    chk1("zero_out_valid_c5_f1", f1_out_valid, 1'b1);
    chk1("zero_out_valid_c5_f0", f0_out_valid, 1'b1);
    chk_s("zero_out_state_f1", f1_out_state, all63);
    chk_s("zero_out_state_f0", f0_out_state, all63);
    chk1("zero_in_ready_c5", f1_in_ready, 1'b1);
    tick();
    chk1("zero_idle_busy", f1_busy, 1'b0);
    chk1("zero_idle_out_valid", f1_out_valid, 1'b0);

    // SubWord in IDLE: known vector then random words
    ks_valid = 1'b1; ks_word = {8'h53, 8'h00, 8'h01, 8'hFF}; #1;
    chk1("ks_idle_ready_f1", f1_ks_ready, 1'b1);
    chk1("ks_idle_ready_f0", f0_ks_ready, 1'b1);
    tick(); ks_valid = 1'b0;
    chk1("ks_idle_res_valid", f1_ks_res_valid, 1'b1);
    chk_w("ks_idle_res_f1", f1_ks_res, 32'hED637C16);
    chk_w("ks_idle_res_f0", f0_ks_res, 32'hED637C16);
    tick();
    chk1("ks_res_valid_drop", f1_ks_res_valid, 1'b0);
    chk_w("ks_res_hold", f1_ks_res, 32'hED637C16);
    for (int i = 0; i < 6; i++) begin
      w = word_t'($urandom);
      ks_valid = 1'b1; ks_word = w; #1;
      chk1("ks_rand_ready", f1_ks_ready, 1'b1);
      tick();
      chk1("ks_rand_res_valid", f1_ks_res_valid, 1'b1);
      chk_w("ks_rand_res_f1", f1_ks_res, sub_word(w));
      chk_w("ks_rand_res_f0", f0_ks_res, sub_word(w));
    end
    ks_valid = 1'b0;
    tick();

    // ks_valid high through RUN: FAIR=1 alternates, FAIR=0 stalls cipher
    st = rand_state(); exp_s = sub_state(st);
    in_state = st; in_valid = 1'b1; out_ready = 1'b0; #1;
    tick(); in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      w = word_t'($urandom);
      g = ((c % 2) == 1);
      ks_valid = 1'b1; ks_word = w; #1;
      chk1("fair_grant_f1", f1_ks_ready, g);
      chk1("strict_grant_f0", f0_ks_ready, 1'b1);
      chk1("fair_out_valid_early_f1", f1_out_valid, 1'b0);
      chk1("strict_out_valid_f0", f0_out_valid, 1'b0);
      chk1("strict_busy_f0", f0_busy, 1'b1);
      tick();
      chk1("fair_res_valid_f1", f1_ks_res_valid, g);
      if (g) chk_w("fair_res_f1", f1_ks_res, sub_word(w));
      chk_w("strict_res_f0", f0_ks_res, sub_word(w));
    end
    ks_valid = 1'b0; #1;
    chk1("fair_out_valid_c9_f1", f1_out_valid, 1'b1);
    chk_s("fair_out_state_f1", f1_out_state, exp_s);
    for (int c = 9; c <= 12; c++) begin
      chk1("hold_out_valid_f1", f1_out_valid, 1'b1);
      chk_s("hold_stable_f1", f1_out_state, exp_s);
      chk1("hold_in_ready_f1", f1_in_ready, 1'b0);
      chk1("stall_resume_out_valid_f0", f0_out_valid, 1'b0);
      tick();
    end
    chk1("stall_done_out_valid_f0", f0_out_valid, 1'b1);
    chk_s("stall_out_state_f0", f0_out_state, exp_s);
    chk_s("hold_long_f1", f1_out_state, exp_s);

    // Back-to-back handover and new acceptance in one cycle
    st2 = rand_state();
    in_state = st2; in_valid = 1'b1; out_ready = 1'b1; #1;
    chk1("b2b_in_ready_f1", f1_in_ready, 1'b1);
    chk1("b2b_in_ready_f0", f0_in_ready, 1'b1);
    chk1("b2b_out_valid_f1", f1_out_valid, 1'b1);
    tick(); in_valid = 1'b0;
    chk1("b2b_out_valid_drop_f1", f1_out_valid, 1'b0);
    chk1("b2b_busy_f0", f0_busy, 1'b1);
    chk1("b2b_in_ready_run", f1_in_ready, 1'b0);
    repeat (3) tick();
    chk1("b2b_out_valid_early", f1_out_valid, 1'b0);
    tick();
    chk1("b2b_out_valid_f1", f1_out_valid, 1'b1);
    chk_s("b2b_out_state_f1", f1_out_state, sub_state(st2));
    chk_s("b2b_out_state_f0", f0_out_state, sub_state(st2));
    tick();

    // FAIR=0: ks_valid cycles 1-3 only
    st = rand_state(); exp_s = sub_state(st);
    in_state = st; in_valid = 1'b1; #1;
    tick(); in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      w = word_t'($urandom);
      g = (c != 2);
      ks_valid = 1'b1; ks_word = w; #1;
      chk1("burst_grant_f0", f0_ks_ready, 1'b1);
      chk1("burst_grant_f1", f1_ks_ready, g);
      tick();
      chk_w("burst_res_f0", f0_ks_res, sub_word(w));
      chk1("burst_res_valid_f1", f1_ks_res_valid, g);
      if (g) chk_w("burst_res_f1", f1_ks_res, sub_word(w));
    end
    ks_valid = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      #1;
      chk1("burst_out_valid_f0", f0_out_valid, (c == 8));
      chk1("burst_out_valid_f1", f1_out_valid, (c == 7));
      if (c == 7) chk_s("burst_out_state_f1", f1_out_state, exp_s);
      if (c == 8) chk_s("burst_out_state_f0", f0_out_state, exp_s);
      tick();
    end
    tick();

    // Random jobs with random consumer stall
    for (int j = 0; j < 5; j++) begin
      st = rand_state(); exp_s = sub_state(st);
      in_state = st; in_valid = 1'b1; out_ready = 1'b0; #1;
      chk1("rnd_in_ready", f1_in_ready, 1'b1);
      tick(); in_valid = 1'b0;
      repeat (4) tick();
      chk1("rnd_out_valid", f1_out_valid, 1'b1);
      chk_s("rnd_out_state_f1", f1_out_state, exp_s);
      chk_s("rnd_out_state_f0", f0_out_state, exp_s);
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        tick();
        chk_s("rnd_hold_stable", f1_out_state, exp_s);
        chk1("rnd_hold_valid", f1_out_valid, 1'b1);
      end
      out_ready = 1'b1; #1;
      chk1("rnd_release_in_ready", f1_in_ready, 1'b1);
      tick();
      chk1("rnd_idle_busy", f1_busy, 1'b0);
    end

    // Reset at beat 2 abandons the job
    st = rand_state();
    in_state = st; in_valid = 1'b1; out_ready = 1'b1; #1;
    tick(); in_valid = 1'b0;
    tick(); tick();
    chk1("midrst_busy_before", f1_busy, 1'b1);
    rst = 1'b0; #1;
    chk1("midrst_busy_f1", f1_busy, 1'b0);
    chk1("midrst_out_valid_f1", f1_out_valid, 1'b0);
    chk_s("midrst_out_state_f1", f1_out_state, '0);
    chk_s("midrst_out_state_f0", f0_out_state, '0);
    chk_w("midrst_ks_res_f1", f1_ks_res, '0);
    chk_w("midrst_ks_res_f0", f0_ks_res, '0);
    chk1("midrst_ks_res_valid", f1_ks_res_valid, 1'b0);
    chk1("midrst_in_ready", f1_in_ready, 1'b1);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk1("postrst_out_valid_f1", f1_out_valid, 1'b0);
      chk1("postrst_out_valid_f0", f0_out_valid, 1'b0);
      chk1("postrst_ks_res_valid", f1_ks_res_valid, 1'b0);
      chk1("postrst_busy", f1_busy, 1'b0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 Parameter: FAIR, default 1; 1 = cipher and key-schedule alternate on contention, 0 = key-schedule has strict priority.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 in_valid  in  1  cipher state offered.
REQ-005 in_ready  out  1  cipher state accepted when in_valid && in_ready at rising edge.
REQ-006 in_state  in  8x4x4  AES state, row-major [row][col].
REQ-007 out_valid  out  1  substituted state available.
REQ-008 out_ready  in  1  consumer accepts out_state.
REQ-009 out_state  out  8x4x4  SubBytes(in_state).
REQ-010 ks_valid  in  1  key-schedule SubWord request.
REQ-011 ks_ready  out  1  SubWord granted this cycle.
REQ-012 ks_word  in  8x4  word to substitute.
REQ-013 ks_res_valid  out  1  one-cycle pulse, ks_res valid; no backpressure.
REQ-014 ks_res  out  8x4  SubWord(ks_word).
REQ-015 busy  out  1  high in RUN or HOLD.

Function
REQ-016 The block SHALL time-share exactly 4 sbox instances between the cipher job (4 beats, one row per beat) and SubWord requests (1 beat).
REQ-017 FSM states SHALL be IDLE, RUN (beat counter 0..3), HOLD.
REQ-018 in_ready SHALL be high in IDLE, or in HOLD when out_ready is high (back-to-back); acceptance loads in_state into the working buffer, clears beat, enters RUN.
REQ-019 Per RUN cycle the slot SHALL go to key-schedule if ks_valid and (FAIR=0 or previous slot owner was cipher); otherwise to the cipher beat.
REQ-020 A cipher beat SHALL write sbox(row[beat]) back in place into the buffer and increment beat; the write of beat 3 SHALL move to HOLD.
REQ-021 In IDLE and HOLD, ks_valid SHALL always be granted.
REQ-022 ks_ready SHALL be combinational and equal to the grant; ks_res/ks_res_valid SHALL be registered and appear the cycle after grant.
REQ-023 With no contention, acceptance at edge of cycle 0 SHALL yield out_valid from cycle 5; each key-schedule slot taken during RUN adds 1 cycle; with FAIR=1 worst case is cycle 9.
REQ-024 out_valid SHALL remain high and out_state SHALL remain stable while out_ready is low; HOLD->IDLE on out_ready unless a new acceptance occurs the same cycle.
REQ-025 With FAIR=0 and ks_valid continuously high, the cipher job SHALL stall indefinitely without losing buffer contents.
REQ-026 ks_res SHALL hold its last value when ks_res_valid is low.

Reset
REQ-027 On rst low: state IDLE, beat 0, previous owner = cipher, buffer/out_state/ks_res = 0, out_valid = 0, ks_res_valid = 0, busy = 0; in_ready = 1 once in IDLE.
REQ-028 Reset mid-RUN or HOLD SHALL abandon the job with no out_valid or ks_res_valid pulse after release.

Structure
REQ-029 The shared package SHALL hold the 8x4x4 state and 8x4 word typedefs, the FSM state enum, and the owner enum (CIPHER/KS).
REQ-030 The existing sbox module SHALL be the only sub-module, instantiated 4 times; the sbox mux and arbiter SHALL stay in sub_bytes_seq.

Verification
REQ-031 in_state all 0x00 accepted cycle 0, out_ready=1, ks idle -> out_valid cycle 5, all bytes 0x63, in_ready high cycle 5.
REQ-032 IDLE, ks_word {0x53,0x00,0x01,0xFF} -> ks_ready same cycle; next cycle ks_res_valid with {0xED,0x63,0x7C,0x16}.
REQ-033 FAIR=1, ks_valid held high throughout RUN -> grants alternate KS,C,KS,C...; out_valid cycle 9; 4 SubWord results correct.
REQ-034 FAIR=0, ks_valid high cycles 1-3 then low -> cipher beats cycles 4-7, out_valid cycle 8.
REQ-035 out_ready low for 3 cycles in HOLD -> out_state stable, in_ready low; out_ready high with in_valid -> handover plus new acceptance in the same cycle.
REQ-036 rst low at beat 2 -> all outputs 0 immediately; after release IDLE, no out_valid.
